// File: rtl/main_fsm_if.sv
// rtl/main_fsm_if.sv - control bus between main_fsm and datapath/cond-logic; MAIN_FSM_MEM_WAIT_EN adds MemReady/MemTimeout
interface main_fsm_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic               ALUOp;
  logic               NextPC;
  logic               RegW;
  logic               MemW;
  logic               Branch;
  logic [STATE_W-1:0] State;
`ifdef MAIN_FSM_MEM_WAIT_EN
  logic               MemReady;
  logic               MemTimeout;

  // FSM side: consumes instruction fields and memory ready, drives controls
  modport slave (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State, MemTimeout
  );

  // Datapath side: supplies instruction fields and memory ready, observes controls
  modport master (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State, MemTimeout
  );
`else
  // FSM side: consumes instruction fields, drives controls
  modport slave (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State
  );

  // Datapath side: supplies instruction fields, observes controls
  modport master (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, State
  );
`endif
endinterface

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multi-cycle ARM main control FSM; MAIN_FSM_MEM_WAIT_EN adds memory wait/timeout
module main_fsm #(
  parameter int STATE_W  = 4
`ifdef MAIN_FSM_MEM_WAIT_EN
  , parameter int WAIT_MAX = 15
`endif
) (
  input  logic      clk,
  input  logic      reset,
  main_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   ready;      // memory access completes this cycle
  logic   timeout;    // memory access abandoned this cycle
  logic   mem_state;  // states that touch memory and may wait
  logic   no_wb;      // CMP/CMN only set flags

  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign no_wb     = (bus.Funct[4:1] == 4'b1010) || (bus.Funct[4:1] == 4'b1011);

`ifdef MAIN_FSM_MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] cnt_q;

  // Ready arriving on the last allowed cycle wins over the timeout
  assign ready   = bus.MemReady;
  assign timeout = mem_state && !bus.MemReady && (cnt_q == CNT_W'(WAIT_MAX));

  // Wait counter: counts waiting cycles, zero whenever a memory state is left or retried
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (mem_state && !ready && !timeout) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign bus.MemTimeout = reset & timeout;
`else
  assign ready   = 1'b1;
  assign timeout = 1'b0;
`endif

  // Next-state selection; memory states hold until ready, timeout drops back to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = ready ? MEMWB : (timeout ? FETCH : MEMRD);
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = (ready || timeout) ? FETCH : MEMWR;
      EXECR,
      EXECI:  state_d = no_wb ? FETCH : ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // State register, asynchronously parked in FETCH during reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic       irwrite, adrsrc, aluop, nextpc, regw, memw, branch;
  logic [1:0] alusrca, alusrcb, resultsrc;

  // Moore decode of the registered state; only the fetch strobes also look at ready
  always_comb begin
    irwrite   = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    aluop     = 1'b0;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite   = ready;
        nextpc    = ready;
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      DECODE: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      MEMADR: alusrcb = 2'b01;
      MEMRD:  adrsrc  = 1'b1;
      MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      EXECR:  aluop = 1'b1;
      EXECI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      ALUWB:  regw = 1'b1;
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Everything reads zero while reset is held, even though the state register holds FETCH
  assign bus.IRWrite   = reset & irwrite;
  assign bus.AdrSrc    = reset & adrsrc;
  assign bus.ALUSrcA   = {2{reset}} & alusrca;
  assign bus.ALUSrcB   = {2{reset}} & alusrcb;
  assign bus.ResultSrc = {2{reset}} & resultsrc;
  assign bus.ALUOp     = reset & aluop;
  assign bus.NextPC    = reset & nextpc;
  assign bus.RegW      = reset & regw;
  assign bus.MemW      = reset & memw;
  assign bus.Branch    = reset & branch;
  assign bus.State     = reset ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - self-checking bench for main_fsm (default build; MAIN_FSM_MEM_WAIT_EN adds wait/timeout sequences)
module tb_main_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_fsm_if #(.STATE_W(4)) bus ();

  main_fsm #(
    .STATE_W(4)
`ifdef MAIN_FSM_MEM_WAIT_EN
    , .WAIT_MAX(3)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    int          len;
    logic [23:0] seq;   // state per cycle, nibble 0 first
    int          wr;    // RegW+MemW+Branch pulses expected
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch}
  function automatic logic [12:0] exp_out(input logic [3:0] s);
    case (s)
      4'd0:    return 13'b1_0_01_10_10_0_1_0_0_0;
      4'd1:    return 13'b0_0_01_10_10_0_0_0_0_0;
      4'd2:    return 13'b0_0_00_01_00_0_0_0_0_0;
      4'd3:    return 13'b0_1_00_00_00_0_0_0_0_0;
      4'd4:    return 13'b0_0_00_00_01_0_0_1_0_0;
      4'd5:    return 13'b0_1_00_00_00_0_0_0_1_0;
      4'd6:    return 13'b0_0_00_00_00_1_0_0_0_0;
      4'd7:    return 13'b0_0_00_01_00_1_0_0_0_0;
      4'd8:    return 13'b0_0_00_00_00_0_0_1_0_0;
      4'd9:    return 13'b0_0_00_01_10_0_0_0_0_1;
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic [12:0] get_out();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.Branch};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [3:0] s);
    check({name, " State"}, 32'(bus.State), 32'(s));
    check({name, " outputs"}, 32'(get_out()), 32'(exp_out(s)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irw, npc, wr;
    logic [3:0] es;

    vecs[0] = '{2'b00, 6'b001000, 4, 24'h008610, 1};  // ADD reg
    vecs[1] = '{2'b00, 6'b110101, 3, 24'h000710, 0};  // CMP imm
    vecs[2] = '{2'b01, 6'b011001, 5, 24'h043210, 1};  // LDR
    vecs[3] = '{2'b01, 6'b011000, 4, 24'h005210, 1};  // STR
    vecs[4] = '{2'b10, 6'b000000, 3, 24'h000910, 1};  // B
    vecs[5] = '{2'b11, 6'b111111, 2, 24'h000010, 0};  // undefined
    vecs[6] = '{2'b00, 6'b101000, 4, 24'h008710, 1};  // ADD imm
    vecs[7] = '{2'b00, 6'b010111, 3, 24'h000610, 0};  // CMN reg
    vecs[8] = '{2'b00, 6'b000101, 4, 24'h008610, 1};  // SUBS reg
    vecs[9] = '{2'b00, 6'b010101, 3, 24'h000610, 0};  // CMP reg

    reset     = 1'b0;
    bus.Op    = 2'b00;
    bus.Funct = 6'b000000;
`ifdef MAIN_FSM_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif

    // Held in reset: everything zero
    repeat (3) begin
      @(negedge clk);
      check("reset State", 32'(bus.State), 32'd0);
      check("reset outputs", 32'(get_out()), 32'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;

    // Back-to-back instructions from the table
    for (int v = 0; v < NV; v++) begin
      irw = 0; npc = 0; wr = 0;
      for (int c = 0; c < vecs[v].len; c++) begin
        @(negedge clk);
        if (c == 0) begin
          bus.Op    = vecs[v].op;
          bus.Funct = vecs[v].funct;
        end
        es = vecs[v].seq[4*c +: 4];
        check_state($sformatf("v%0d c%0d", v, c), es);
        irw += int'(bus.IRWrite);
        npc += int'(bus.NextPC);
        wr  += int'(bus.RegW) + int'(bus.MemW) + int'(bus.Branch);
      end
      check($sformatf("v%0d IRWrite pulses", v), 32'(irw), 32'd1);
      check($sformatf("v%0d NextPC pulses", v), 32'(npc), 32'd1);
      check($sformatf("v%0d write pulses", v), 32'(wr), 32'(vecs[v].wr));
    end

    // Reset asserted in MEMRD of an LDR: no writeback, resume at FETCH
    @(negedge clk);
    bus.Op = 2'b01; bus.Funct = 6'b011001;
    check_state("midrst fetch", 4'd0);
    @(negedge clk); check_state("midrst decode", 4'd1);
    @(negedge clk); check_state("midrst memadr", 4'd2);
    @(negedge clk); check_state("midrst memrd", 4'd3);
    reset = 1'b0;
    #1;
    check("midrst held State", 32'(bus.State), 32'd0);
    check("midrst held outputs", 32'(get_out()), 32'd0);
    @(negedge clk);
    check("midrst held2 outputs", 32'(get_out()), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    bus.Op = 2'b10;
    @(negedge clk); check_state("midrst resume fetch", 4'd0);
    @(negedge clk); check_state("midrst resume decode", 4'd1);
    @(negedge clk); check_state("midrst resume branch", 4'd9);
    @(negedge clk); check_state("midrst resume next", 4'd0);

`ifdef MAIN_FSM_MEM_WAIT_EN
    // LDR with MemReady low in MEMRD: 3 waits, timeout cycle, then FETCH
    bus.Op = 2'b01; bus.Funct = 6'b011001;
    @(negedge clk); check("wt decode State", 32'(bus.State), 32'd1);
    @(negedge clk); check("wt memadr State", 32'(bus.State), 32'd2);
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("wt wait%0d State", i), 32'(bus.State), 32'd3);
      check($sformatf("wt wait%0d MemTimeout", i), 32'(bus.MemTimeout), 32'd0);
    end
    @(negedge clk);
    check("wt expire State", 32'(bus.State), 32'd3);
    check("wt expire MemTimeout", 32'(bus.MemTimeout), 32'd1);
    bus.MemReady = 1'b1;
    @(negedge clk);
    check("wt after State", 32'(bus.State), 32'd0);
    check("wt after MemTimeout", 32'(bus.MemTimeout), 32'd0);
    // Same LDR, ready on the 2nd wait cycle
    @(negedge clk); check("wr decode State", 32'(bus.State), 32'd1);
    @(negedge clk); check("wr memadr State", 32'(bus.State), 32'd2);
    bus.MemReady = 1'b0;
    @(negedge clk); check("wr wait0 State", 32'(bus.State), 32'd3);
    @(negedge clk);
    bus.MemReady = 1'b1;
    check("wr wait1 State", 32'(bus.State), 32'd3);
    check("wr wait1 MemTimeout", 32'(bus.MemTimeout), 32'd0);
    @(negedge clk);
    check("wr memwb State", 32'(bus.State), 32'd4);
    check("wr memwb MemTimeout", 32'(bus.MemTimeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
